// File: rtl/fp_divider_iterative.sv
// -----------------------------------------------------------------------------
// fp_divider_iterative
//   IEEE-754 single-precision divider built around a radix-2 restoring
//   mantissa divider that retires ITER_PER_CYCLE quotient bits per clock.
//   One operation is in flight at a time; a new one is accepted only while
//   the block is idle. Denormal inputs are flushed to signed zero.
//
// Ports
//   clk                input   clock
//   rst_n              input   asynchronous active-low reset
//   valid_in           input   operands present
//   ready_out          output  block idle, can accept
//   a, b               input   dividend / divisor, IEEE-754 single
//   rounding_mode      input   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//   out                output  quotient a/b, registered, held until next result
//   valid_out          output  one-cycle result strobe
//   overflow, underflow, inexact, invalid_operation, division_by_zero
//                      output  IEEE flags belonging to out
// -----------------------------------------------------------------------------
module fp_divider_iterative #(
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  rounding_mode,
   output logic [31:0] out,
   output logic        valid_out,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact,
   output logic        invalid_operation,
   output logic        division_by_zero
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] UNPACK = 3'd1;
   localparam logic [2:0] DIVIDE = 3'd2;
   localparam logic [2:0] ROUND  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [4:0] QBITS = 5'd27;

   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   logic [2:0]         state;
   logic [31:0]        a_r;
   logic [31:0]        b_r;
   logic [2:0]         rm_r;
   logic [4:0]         cnt;
   logic [25:0]        rem;
   logic [23:0]        dvsr;
   logic [26:0]        quo;
   logic               sign_r;
   logic signed [9:0]  exp_r;
   logic               special_r;
   logic [31:0]        spec_out_r;
   logic               spec_inv_r;
   logic               spec_dz_r;
   logic               flush_r;

   assign ready_out = (state == IDLE);

   // ---------------------------------------------------------------------------
   // Operand classification (on the captured operands, used in UNPACK).
   // A denormal has exponent 0, so treating exponent 0 as zero is the flush.
   // ---------------------------------------------------------------------------
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic       flush_any, res_sign;
   logic       is_special;
   logic [31:0] sp_out;
   logic       sp_inv, sp_dz;

   assign a_zero    = (a_r[30:23] == 8'h00);
   assign b_zero    = (b_r[30:23] == 8'h00);
   assign a_inf     = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
   assign b_inf     = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
   assign a_nan     = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
   assign b_nan     = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
   assign a_snan    = a_nan && !a_r[22];
   assign b_snan    = b_nan && !b_r[22];
   assign flush_any = (a_zero && (a_r[22:0] != 23'd0)) || (b_zero && (b_r[22:0] != 23'd0));
   assign res_sign  = a_r[31] ^ b_r[31];

   // Special cases in priority order; is_special=0 means the mantissa path runs.
   always_comb begin
      is_special = 1'b1;
      sp_out     = 32'd0;
      sp_inv     = 1'b0;
      sp_dz      = 1'b0;
      if (a_nan || b_nan) begin
         sp_out = a_nan ? (a_r | 32'h0040_0000) : (b_r | 32'h0040_0000);
         sp_inv = a_snan || b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_out = 32'h7FC0_0000;
         sp_inv = 1'b1;
      end else if (b_zero) begin
         sp_out = {res_sign, 8'hFF, 23'd0};
         sp_dz  = 1'b1;
      end else if (a_inf) begin
         sp_out = {res_sign, 8'hFF, 23'd0};
      end else if (a_zero || b_inf) begin
         sp_out = {res_sign, 31'd0};
      end else begin
         is_special = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Restoring division step(s). The partial remainder stays below twice the
   // divisor, so 26 bits are enough. The last DIVIDE cycle may retire fewer
   // than ITER_PER_CYCLE bits so every setting yields exactly 27 bits.
   // ---------------------------------------------------------------------------
   logic [25:0] rem_n;
   logic [26:0] quo_n;
   logic [4:0]  cnt_n;

   // NOTE: blocking assignments inside always_comb chain the unrolled steps;
   // each step sees the previous step's result within the same cycle.
   always_comb begin
      rem_n = rem;
      quo_n = quo;
      cnt_n = cnt;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         if (cnt_n < QBITS) begin
            if (rem_n >= {2'b00, dvsr}) begin
               rem_n = rem_n - {2'b00, dvsr};
               quo_n = {quo_n[25:0], 1'b1};
            end else begin
               quo_n = {quo_n[25:0], 1'b0};
            end
            rem_n = {rem_n[24:0], 1'b0};
            cnt_n = cnt_n + 5'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Normalisation and rounding of the finished quotient.
   // ---------------------------------------------------------------------------
   logic              q_hi;
   logic [22:0]       mant;
   logic              g_bit, r_bit, s_bit, any_bit, inc;
   logic [23:0]       mant_sum;
   logic signed [9:0] exp_fin;
   logic              ovf, udf;
   logic [31:0]       max_fin, inf_val, ovf_out, norm_out;

   always_comb begin
      q_hi  = quo[26];
      mant  = q_hi ? quo[25:3] : quo[24:2];
      g_bit = q_hi ? quo[2] : quo[1];
      r_bit = q_hi ? quo[1] : quo[0];
      s_bit = (q_hi & quo[0]) | (rem != 26'd0);
      any_bit = g_bit | r_bit | s_bit;

      case (rm_r)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign_r & any_bit;
         RM_RUP:  inc = ~sign_r & any_bit;
         RM_RMM:  inc = g_bit;
         default: inc = g_bit & (r_bit | s_bit | mant[0]);
      endcase

      // A carry into bit 23 leaves the low 23 bits zero, which is exactly the
      // zeroed mantissa that goes with the incremented exponent.
      mant_sum = {1'b0, mant} + {23'd0, inc};
      exp_fin  = exp_r - $signed({9'd0, ~q_hi}) + $signed({9'd0, mant_sum[23]});
      ovf      = (exp_fin > 10'sd254);
      udf      = (exp_fin <= 10'sd0);

      max_fin  = {sign_r, 31'h7F7F_FFFF};
      inf_val  = {sign_r, 8'hFF, 23'd0};
      case (rm_r)
         RM_RTZ:  ovf_out = max_fin;
         RM_RDN:  ovf_out = sign_r ? inf_val : max_fin;
         RM_RUP:  ovf_out = sign_r ? max_fin : inf_val;
         default: ovf_out = inf_val;
      endcase

      norm_out = {sign_r, exp_fin[7:0], mant_sum[22:0]};
   end

   // ---------------------------------------------------------------------------
   // Control and datapath registers.
   // ---------------------------------------------------------------------------
   // NOTE: every datapath register is reset, not just the FSM, so an aborted
   // operation leaves no stale remainder or quotient behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         a_r               <= 32'd0;
         b_r               <= 32'd0;
         rm_r              <= 3'd0;
         cnt               <= 5'd0;
         rem               <= 26'd0;
         dvsr              <= 24'd0;
         quo               <= 27'd0;
         sign_r            <= 1'b0;
         exp_r             <= 10'sd0;
         special_r         <= 1'b0;
         spec_out_r        <= 32'd0;
         spec_inv_r        <= 1'b0;
         spec_dz_r         <= 1'b0;
         flush_r           <= 1'b0;
         out               <= 32'd0;
         valid_out         <= 1'b0;
         overflow          <= 1'b0;
         underflow         <= 1'b0;
         inexact           <= 1'b0;
         invalid_operation <= 1'b0;
         division_by_zero  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state so every register
         // samples the pre-edge values regardless of statement order.
         valid_out <= (state == ROUND);
         case (state)
            IDLE: begin
               if (valid_in) begin
                  a_r   <= a;
                  b_r   <= b;
                  rm_r  <= rounding_mode;
                  state <= UNPACK;
               end
            end
            UNPACK: begin
               sign_r     <= res_sign;
               special_r  <= is_special;
               spec_out_r <= sp_out;
               spec_inv_r <= sp_inv;
               spec_dz_r  <= sp_dz;
               flush_r    <= flush_any;
               exp_r      <= $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;
               rem        <= {2'b01, a_r[22:0]};
               dvsr       <= {1'b1, b_r[22:0]};
               quo        <= 27'd0;
               cnt        <= 5'd0;
               state      <= is_special ? ROUND : DIVIDE;
            end
            DIVIDE: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt_n;
               if (cnt_n >= QBITS) state <= ROUND;
            end
            ROUND: begin
               if (special_r) begin
                  out               <= spec_out_r;
                  overflow          <= 1'b0;
                  underflow         <= flush_r;
                  inexact           <= 1'b0;
                  invalid_operation <= spec_inv_r;
                  division_by_zero  <= spec_dz_r;
               end else begin
                  invalid_operation <= 1'b0;
                  division_by_zero  <= 1'b0;
                  if (ovf) begin
                     out       <= ovf_out;
                     overflow  <= 1'b1;
                     underflow <= 1'b0;
                     inexact   <= 1'b1;
                  end else if (udf) begin
                     out       <= {sign_r, 31'd0};
                     overflow  <= 1'b0;
                     underflow <= 1'b1;
                     inexact   <= 1'b1;
                  end else begin
                     out       <= norm_out;
                     overflow  <= 1'b0;
                     underflow <= flush_r;
                     inexact   <= any_bit;
                  end
               end
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider_iterative.sv
// -----------------------------------------------------------------------------
// tb_fp_divider_iterative
//   Self-checking bench for fp_divider_iterative. Directed cases carry literal
//   expectations; random operands are checked against a behavioural model that
//   divides integer mantissas directly and applies the rounding rules.
//   Cycle n after a transfer is the clock period that begins at the n-th
//   rising edge following the transfer edge (the transfer edge itself opens
//   cycle 1, which is UNPACK).
// -----------------------------------------------------------------------------
module tb_fp_divider_iterative;

   localparam int ITER  = 1;
   localparam int LAT_N = 3 + (27 + ITER - 1) / ITER;
   localparam int LAT_S = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] a, b;
   logic [2:0]  rounding_mode;
   logic [31:0] out;
   logic        valid_out;
   logic        overflow, underflow, inexact, invalid_operation, division_by_zero;

   fp_divider_iterative #(.ITER_PER_CYCLE(ITER)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .valid_in          (valid_in),
      .ready_out         (ready_out),
      .a                 (a),
      .b                 (b),
      .rounding_mode     (rounding_mode),
      .out               (out),
      .valid_out         (valid_out),
      .overflow          (overflow),
      .underflow         (underflow),
      .inexact           (inexact),
      .invalid_operation (invalid_operation),
      .division_by_zero  (division_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] out;
      logic        ov;
      logic        uf;
      logic        ix;
      logic        inv;
      logic        dz;
      logic        spec;
   } res_t;

   int tests = 0;
   int fails = 0;
   logic [31:0] prev_out   = 32'd0;
   logic [4:0]  prev_flags = 5'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] dut_flags();
      return {overflow, underflow, inexact, invalid_operation, division_by_zero};
   endfunction

   // Behavioural reference: integer division of the full significands.
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
      res_t r;
      logic s, fl, an, bn, ai, bi, az, bz, g, rr, st, inc;
      int ex, ey, e;
      logic [22:0] fx, fy, mant;
      longint unsigned num, den, q, rem, sig;
      r  = '0;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      fx = x[22:0];
      fy = y[22:0];
      fl = 1'b0;
      if (ex == 0 && fx != 0) begin fx = '0; fl = 1'b1; end
      if (ey == 0 && fy != 0) begin fy = '0; fl = 1'b1; end
      an = (ex == 255) && (fx != 0);
      bn = (ey == 255) && (fy != 0);
      ai = (ex == 255) && (fx == 0);
      bi = (ey == 255) && (fy == 0);
      az = (ex == 0);
      bz = (ey == 0);
      r.uf   = fl;
      r.spec = 1'b1;
      if (an || bn) begin
         r.out = an ? {x[31:23], 1'b1, x[21:0]} : {y[31:23], 1'b1, y[21:0]};
         r.inv = (an && !x[22]) || (bn && !y[22]);
      end else if ((az && bz) || (ai && bi)) begin
         r.out = 32'h7FC0_0000;
         r.inv = 1'b1;
      end else if (bz) begin
         r.out = {s, 31'h7F80_0000};
         r.dz  = 1'b1;
      end else if (ai) begin
         r.out = {s, 31'h7F80_0000};
      end else if (az || bi) begin
         r.out = {s, 31'd0};
      end else begin
         r.spec = 1'b0;
         num = ((64'd1 << 23) | 64'(fx)) << 26;
         den = (64'd1 << 23) | 64'(fy);
         q   = num / den;
         rem = num % den;
         if (q[26]) begin
            mant = q[25:3]; g = q[2]; rr = q[1]; st = q[0] | (rem != 0);
            e = ex - ey + 127;
         end else begin
            mant = q[24:2]; g = q[1]; rr = q[0]; st = (rem != 0);
            e = ex - ey + 126;
         end
         case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s & (g | rr | st);
            3'b011:  inc = !s & (g | rr | st);
            3'b100:  inc = g;
            default: inc = g & (rr | st | mant[0]);
         endcase
         sig = ((64'd1 << 23) | 64'(mant)) + 64'(inc);
         if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
         end
         if (e > 254) begin
            r.ov = 1'b1;
            r.ix = 1'b1;
            case (rm)
               3'b001:  r.out = {s, 31'h7F7F_FFFF};
               3'b010:  r.out = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
               3'b011:  r.out = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
               default: r.out = {s, 31'h7F80_0000};
            endcase
         end else if (e <= 0) begin
            r.out = {s, 31'd0};
            r.uf  = 1'b1;
            r.ix  = 1'b1;
         end else begin
            r.out = {s, 8'(e), sig[22:0]};
            r.ix  = g | rr | st;
         end
      end
      return r;
   endfunction

   // One operation: drive, transfer, watch every cycle until the pulse window
   // closes, then compare with the model (and with a literal when given).
   task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic [2:0] orm,
                         input bit hold_valid, input bit use_lit, input res_t lit, input string tag);
      res_t exp_r;
      int lat, first, pulses;
      bit held;
      logic [31:0] cap_out;
      logic [4:0]  cap_flags;
      exp_r = model(oa, ob, orm);
      if (use_lit) check({tag, " model"}, 64'(exp_r), 64'(lit));
      lat = exp_r.spec ? LAT_S : LAT_N;
      for (int k = 0; k < 40 && !ready_out; k++) @(negedge clk);
      check({tag, " ready"}, 64'(ready_out), 64'd1);
      valid_in = 1'b1; a = oa; b = ob; rounding_mode = orm;
      @(posedge clk);
      first = 0; pulses = 0; held = 1'b1; cap_out = '0; cap_flags = '0;
      for (int n = 1; n <= lat + 4; n++) begin
         @(negedge clk);
         if (valid_out) begin
            pulses++;
            if (first == 0) begin
               first     = n;
               cap_out   = out;
               cap_flags = dut_flags();
            end
         end else if (first == 0) begin
            if (out !== prev_out || dut_flags() !== prev_flags) held = 1'b0;
         end else if (out !== cap_out || dut_flags() !== cap_flags) begin
            held = 1'b0;
         end
         if (hold_valid && first == 0) begin
            a = $urandom; b = $urandom; rounding_mode = 3'($urandom_range(0, 4));
         end else begin
            valid_in = 1'b0;
         end
      end
      check({tag, " latency"}, 64'(first), 64'(lat));
      check({tag, " pulses"}, 64'(pulses), 64'd1);
      check({tag, " hold"}, 64'(held), 64'd1);
      check({tag, " out"}, 64'(cap_out), 64'(exp_r.out));
      check({tag, " flags"}, 64'(cap_flags), 64'({exp_r.ov, exp_r.uf, exp_r.ix, exp_r.inv, exp_r.dz}));
      prev_out   = exp_r.out;
      prev_flags = {exp_r.ov, exp_r.uf, exp_r.ix, exp_r.inv, exp_r.dz};
   endtask

   function automatic logic [31:0] rand_operand();
      logic [22:0] m;
      m = 23'($urandom);
      case ($urandom_range(0, 15))
         0:       return {1'($urandom), 31'd0};
         1:       return {1'($urandom), 8'hFF, 23'd0};
         2:       return {1'($urandom), 8'hFF, 1'b1, m[21:0]};
         3:       return {1'($urandom), 8'hFF, 1'b0, m[21:1], 1'b1};
         4:       return {1'($urandom), 8'h00, m[22:1], 1'b1};
         5:       return {1'($urandom), 8'($urandom_range(200, 254)), m};
         6:       return {1'($urandom), 8'($urandom_range(1, 50)), m};
         7:       return {1'($urandom), 8'($urandom_range(100, 154)), 23'd0};
         default: return {1'($urandom), 8'($urandom_range(100, 154)), m};
      endcase
   endfunction

   res_t none = '0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      int pulses;
      valid_in = 1'b0; a = '0; b = '0; rounding_mode = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset out", 64'(out), 64'd0);
      check("reset flags", 64'(dut_flags()), 64'd0);
      check("reset valid_out", 64'(valid_out), 64'd0);
      check("reset ready_out", 64'(ready_out), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 0, 1, '{32'h4040_0000, 0, 0, 0, 0, 0, 0}, "6/2 rne");
      run_op(32'h3F80_0000, 32'h4040_0000, 3'b000, 0, 1, '{32'h3EAA_AAAB, 0, 0, 1, 0, 0, 0}, "1/3 rne");
      run_op(32'h3F80_0000, 32'h4040_0000, 3'b001, 0, 1, '{32'h3EAA_AAAA, 0, 0, 1, 0, 0, 0}, "1/3 rtz");
      run_op(32'h3F80_0000, 32'h0000_0000, 3'b000, 0, 1, '{32'h7F80_0000, 0, 0, 0, 0, 1, 1}, "1/0");
      run_op(32'h0000_0000, 32'h0000_0000, 3'b000, 0, 1, '{32'h7FC0_0000, 0, 0, 0, 1, 0, 1}, "0/0");
      run_op(32'h7F00_0000, 32'h3E80_0000, 3'b000, 0, 1, '{32'h7F80_0000, 1, 0, 1, 0, 0, 0}, "ovf rne");
      run_op(32'h7F00_0000, 32'h3E80_0000, 3'b001, 0, 1, '{32'h7F7F_FFFF, 1, 0, 1, 0, 0, 0}, "ovf rtz");
      run_op(32'hFF00_0000, 32'h3E80_0000, 3'b010, 0, 1, '{32'hFF80_0000, 1, 0, 1, 0, 0, 0}, "ovf rdn");
      run_op(32'h0080_0000, 32'h7F00_0000, 3'b000, 0, 1, '{32'h0000_0000, 0, 1, 1, 0, 0, 0}, "udf");
      run_op(32'h0000_0001, 32'h3F80_0000, 3'b000, 0, 1, '{32'h0000_0000, 0, 1, 0, 0, 0, 1}, "denorm");
      run_op(32'h7F80_0001, 32'h3F80_0000, 3'b000, 0, 1, '{32'h7FC0_0001, 0, 0, 0, 1, 0, 1}, "snan");

      // Operands keep changing with valid_in held high while busy.
      run_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 1, 1, '{32'h4040_0000, 0, 0, 0, 0, 0, 0}, "busy hold");

      // Reset in DIVIDE cycle 10 (cycle 11 after transfer).
      for (int k = 0; k < 40 && !ready_out; k++) @(negedge clk);
      valid_in = 1'b1; a = 32'h40C0_0000; b = 32'h4000_0000; rounding_mode = 3'b000;
      @(posedge clk);
      pulses = 0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         valid_in = 1'b0;
         if (valid_out) pulses++;
      end
      rst_n = 1'b0;
      #1;
      check("abort out", 64'(out), 64'(prev_out & 32'd0));
      check("abort flags", 64'(dut_flags()), 64'd0);
      check("abort ready_out", 64'(ready_out), 64'd1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (valid_out) pulses++;
      end
      check("abort pulses", 64'(pulses), 64'd0);
      rst_n = 1'b1;
      prev_out = 32'd0; prev_flags = 5'd0;
      @(negedge clk);
      run_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 0, 1, '{32'h4040_0000, 0, 0, 0, 0, 0, 0}, "after abort");

      for (int t = 0; t < 150; t++) begin
         ra = rand_operand();
         rb = rand_operand();
         run_op(ra, rb, 3'($urandom_range(0, 4)), 0, 0, none, $sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
